// File: rtl/accumulator_bus_arbiter.sv
// Round-robin arbiter sharing the accumulator memory op/signal port among N_PROC cores.
// IDLE grants one request, WAIT holds it until mem_signal or the watchdog fires, RELEASE pulses p_signal.
module accumulator_bus_arbiter #(
  parameter int N_PROC  = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 2047
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2*N_PROC-1:0]      p_op,
  input  logic [DATA_W*N_PROC-1:0] p_write,
  output logic [N_PROC-1:0]        p_signal,
  output logic [DATA_W-1:0]        p_read,
  output logic [1:0]               mem_op,
  output logic [DATA_W-1:0]        mem_write,
  input  logic [DATA_W-1:0]        mem_read,
  input  logic                     mem_signal,
  output logic                     busy,
  output logic [ID_W-1:0]          grant_id,
  output logic                     timeout_err
);

  localparam int              WD_W     = 16;
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [1:0]      OP_NOP   = 2'b00;
  localparam logic [1:0]      OP_FETCH = 2'b01;
  localparam logic [1:0]      OP_SEND  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t              state_q;
  logic [1:0]          mem_op_q;
  logic [DATA_W-1:0]   mem_write_q;
  logic [N_PROC-1:0]   p_signal_q;
  logic [DATA_W-1:0]   p_read_q;
  logic [ID_W-1:0]     grant_id_q;
  logic [ID_W-1:0]     rr_q;
  logic [WD_W-1:0]     wd_q;
  logic [WD_W-1:0]     wd_d;
  logic                timeout_err_q;

  logic                req_vld;
  logic [ID_W-1:0]     win_idx;
  logic [1:0]          win_op;
  logic [DATA_W-1:0]   win_dat;
  int                  cand;
  logic [1:0]          cand_op;

  // Scan cores rr+1 .. rr+N_PROC (mod N_PROC); the first core with FETCH or SEND wins.
  always_comb begin
    req_vld = 1'b0;
    win_idx = rr_q;
    win_op  = OP_NOP;
    win_dat = '0;
    cand    = 0;
    cand_op = OP_NOP;
    for (int k = 1; k <= N_PROC; k++) begin
      cand = int'(rr_q) + k;
      if (cand >= N_PROC) begin
        cand = cand - N_PROC;
      end
      cand_op = p_op[2*cand +: 2];
      if (!req_vld && (cand_op == OP_FETCH || cand_op == OP_SEND)) begin
        req_vld = 1'b1;
        win_idx = ID_W'(cand);
        win_op  = cand_op;
        win_dat = p_write[DATA_W*cand +: DATA_W];
      end
    end
  end

  assign wd_d = wd_q + WD_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      mem_op_q      <= OP_NOP;
      mem_write_q   <= '0;
      p_signal_q    <= '0;
      p_read_q      <= '0;
      grant_id_q    <= '0;
      rr_q          <= ID_W'(N_PROC - 1);
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_vld) begin
            grant_id_q  <= win_idx;
            rr_q        <= win_idx;
            mem_op_q    <= win_op;
            mem_write_q <= win_dat;
            wd_q        <= '0;
            state_q     <= S_WAIT;
          end else begin
            mem_op_q    <= OP_NOP;
          end
        end
        S_WAIT: begin
          wd_q <= wd_d;
          // Completion takes priority over a watchdog expiry in the same cycle.
          if (mem_signal) begin
            mem_op_q   <= OP_NOP;
            p_read_q   <= mem_read;
            p_signal_q <= N_PROC'(1) << grant_id_q;
            state_q    <= S_RELEASE;
          end else if (wd_q >= WD_LAST) begin
            mem_op_q      <= OP_NOP;
            p_read_q      <= '0;
            p_signal_q    <= N_PROC'(1) << grant_id_q;
            timeout_err_q <= 1'b1;
            state_q       <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          p_signal_q <= '0;
          mem_op_q   <= OP_NOP;
          state_q    <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign p_signal    = p_signal_q;
  assign p_read      = p_read_q;
  assign mem_op      = mem_op_q;
  assign mem_write   = mem_write_q;
  assign busy        = (state_q != S_IDLE);
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_accumulator_bus_arbiter.sv
// Scoreboard bench for accumulator_bus_arbiter: core/memory models drive requests, a monitor pops expectations.
module tb_accumulator_bus_arbiter;

  localparam int N_PROC  = 4;
  localparam int ID_W    = 2;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 2047;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [2*N_PROC-1:0]      p_op;
  logic [DATA_W*N_PROC-1:0] p_write;
  logic [N_PROC-1:0]        p_signal;
  logic [DATA_W-1:0]        p_read;
  logic [1:0]               mem_op;
  logic [DATA_W-1:0]        mem_write;
  logic [DATA_W-1:0]        mem_read;
  logic                     mem_signal;
  logic                     busy;
  logic [ID_W-1:0]          grant_id;
  logic                     timeout_err;

  always #5 clk = ~clk;

  accumulator_bus_arbiter #(
    .N_PROC(N_PROC), .ID_W(ID_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .p_op(p_op), .p_write(p_write),
    .p_signal(p_signal), .p_read(p_read), .mem_op(mem_op), .mem_write(mem_write),
    .mem_read(mem_read), .mem_signal(mem_signal), .busy(busy),
    .grant_id(grant_id), .timeout_err(timeout_err)
  );

  typedef struct {
    int          id;
    logic [1:0]  op;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waitc;
    bit          to;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;
  bit in_txn = 0, prev_busy = 0, post_rel = 0, sticky = 0;
  int wait_cnt = 0;

  logic [1:0]  req_op  [N_PROC];
  logic [31:0] req_dat [N_PROC];
  int          req_cnt [N_PROC];
  int          done_cnt[N_PROC];
  int          mem_lat   = 4;
  bit          mem_en    = 1;
  logic [31:0] mem_rdata = '0;
  int          lat_cnt   = 0;
  bit          responded = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic push_exp(input int id, input logic [1:0] op, input logic [31:0] wd,
                          input logic [31:0] rd, input int waitc, input bit to);
    exp_t e;
    e.id = id; e.op = op; e.wdata = wd; e.rdata = rd; e.waitc = waitc; e.to = to;
    exp_q.push_back(e);
  endtask

  task automatic issue(input int id, input logic [1:0] op, input logic [31:0] dat, input int cnt);
    req_op[id]  = op;
    req_dat[id] = dat;
    req_cnt[id] = req_cnt[id] + cnt;
  endtask

  task automatic wait_busy(input string tag, input int budget);
    int c = 0;
    while (!busy && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    check_eq(tag, 32'(busy), 32'd1);
  endtask

  task automatic wait_pulses(input string tag, input int target, input int budget);
    int c = 0;
    while (n_pulses < target && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    check_eq(tag, 32'(n_pulses), 32'(target));
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    for (int i = 0; i < N_PROC; i++) begin
      req_cnt[i] = 0;
      req_op[i]  = 2'b00;
    end
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk); #1;
    check_eq("rst_mem_op", 32'(mem_op), 32'd0);
    check_eq("rst_mem_write", mem_write, 32'd0);
    check_eq("rst_p_signal", 32'(p_signal), 32'd0);
    check_eq("rst_p_read", p_read, 32'd0);
    check_eq("rst_grant_id", 32'(grant_id), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_timeout_err", 32'(timeout_err), 32'd0);
  endtask

  // Core and memory models: cores withdraw after each pulse; memory answers mem_lat cycles into WAIT.
  initial begin
    mem_signal = 1'b0;
    mem_read   = '0;
    p_op       = '0;
    p_write    = '0;
    for (int i = 0; i < N_PROC; i++) done_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        for (int i = 0; i < N_PROC; i++) done_cnt[i] = 0;
        mem_signal = 1'b0;
        responded  = 0;
        lat_cnt    = 0;
      end else begin
        for (int i = 0; i < N_PROC; i++) begin
          if (p_signal[i]) done_cnt[i]++;
        end
        if (mem_signal) begin
          mem_signal = 1'b0;
        end else if (mem_op != 2'b00 && mem_en && !responded) begin
          if (lat_cnt >= mem_lat - 1) begin
            mem_signal = 1'b1;
            responded  = 1;
          end else begin
            lat_cnt++;
          end
        end
        if (mem_op == 2'b00) begin
          responded = 0;
          lat_cnt   = 0;
        end
      end
      mem_read = mem_rdata;
      for (int i = 0; i < N_PROC; i++) begin
        p_op[2*i +: 2]             = (done_cnt[i] < req_cnt[i]) ? req_op[i] : 2'b00;
        p_write[DATA_W*i +: DATA_W] = req_dat[i];
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      in_txn    = 0;
      prev_busy = 0;
      post_rel  = 0;
      sticky    = 0;
    end else begin
      if (post_rel) begin
        check_eq("nop_gap_mem_op", 32'(mem_op), 32'd0);
        check_eq("nop_gap_busy", 32'(busy), 32'd0);
        post_rel = 0;
      end
      if (busy && !prev_busy) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_grant", 32'(busy), 32'd0);
        end else begin
          cur      = exp_q.pop_front();
          in_txn   = 1;
          wait_cnt = 1;
          check_eq("grant_id", 32'(grant_id), 32'(cur.id));
          check_eq("grant_mem_op", 32'(mem_op), 32'(cur.op));
          check_eq("grant_mem_write", mem_write, cur.wdata);
        end
      end else if (busy && in_txn && p_signal == '0) begin
        wait_cnt++;
        check_eq("wait_hold_op", 32'(mem_op), 32'(cur.op));
        check_eq("wait_hold_write", mem_write, cur.wdata);
      end
      if (p_signal != '0) begin
        if (!in_txn) begin
          check_eq("spurious_pulse", 32'(p_signal), 32'd0);
        end else begin
          n_pulses++;
          if (cur.to) sticky = 1;
          check_eq("pulse_onehot", 32'(p_signal), 32'(1) << cur.id);
          check_eq("pulse_p_read", p_read, cur.rdata);
          check_eq("pulse_mem_op", 32'(mem_op), 32'd0);
          check_eq("pulse_wait_cycles", 32'(wait_cnt), 32'(cur.waitc));
          check_eq("pulse_timeout_err", 32'(timeout_err), 32'(sticky));
          in_txn   = 0;
          post_rel = 1;
        end
      end
      prev_busy = busy;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int base;
    int idle;
    int c;
    for (int i = 0; i < N_PROC; i++) begin
      req_op[i]  = 2'b00;
      req_dat[i] = '0;
      req_cnt[i] = 0;
    end
    reset = 1'b1;

    // Single FETCH from core 2
    do_reset();
    mem_lat = 4; mem_rdata = 32'h0000_00A5;
    base = n_pulses;
    push_exp(2, 2'b01, 32'h0, 32'hA5, 4, 0);
    issue(2, 2'b01, 32'h0, 1);
    wait_pulses("t1_done", base + 1, 50);
    repeat (2) @(negedge clk);

    // All four cores SEND at once: rotation 0..3, one idle cycle between grants
    do_reset();
    mem_lat = 2; mem_rdata = 32'h5A;
    base = n_pulses;
    for (int i = 0; i < N_PROC; i++) begin
      push_exp(i, 2'b10, 32'h11 * (i + 1), 32'h5A, 2, 0);
      issue(i, 2'b10, 32'h11 * (i + 1), 1);
    end
    wait_busy("t2_first_grant", 20);
    idle = 0; c = 0;
    while (n_pulses < base + 4 && c < 200) begin
      @(negedge clk); #1;
      c++;
      if (!busy) idle++;
    end
    check_eq("t2_pulses", 32'(n_pulses), 32'(base + 4));
    check_eq("t2_idle_gaps", 32'(idle), 32'd3);

    // Core 1 continuous, core 3 joins during core 1's WAIT
    do_reset();
    mem_lat = 6; mem_rdata = 32'h77;
    base = n_pulses;
    push_exp(1, 2'b01, 32'hB1, 32'h77, 6, 0);
    issue(1, 2'b01, 32'hB1, 2);
    wait_busy("t3_first_grant", 20);
    repeat (2) @(negedge clk); #1;
    push_exp(3, 2'b10, 32'hC3, 32'h77, 6, 0);
    push_exp(1, 2'b01, 32'hB1, 32'h77, 6, 0);
    issue(3, 2'b10, 32'hC3, 1);
    wait_pulses("t3_done", base + 3, 100);

    // Completion on the last watchdog cycle, then a real timeout, then normal service
    do_reset();
    mem_lat = TIMEOUT; mem_rdata = 32'h3C;
    base = n_pulses;
    push_exp(0, 2'b01, 32'h0, 32'h3C, TIMEOUT, 0);
    issue(0, 2'b01, 32'h0, 1);
    wait_pulses("t4_tie_done", base + 1, TIMEOUT + 50);
    check_eq("t4_tie_no_err", 32'(timeout_err), 32'd0);
    mem_en = 0; mem_rdata = 32'hDEAD_BEEF;
    push_exp(1, 2'b10, 32'h99, 32'h0, TIMEOUT, 1);
    issue(1, 2'b10, 32'h99, 1);
    wait_pulses("t4_timeout_done", base + 2, TIMEOUT + 50);
    check_eq("t4_err_set", 32'(timeout_err), 32'd1);
    mem_en = 1; mem_lat = 3; mem_rdata = 32'h42;
    push_exp(2, 2'b01, 32'h0, 32'h42, 3, 0);
    issue(2, 2'b01, 32'h0, 1);
    wait_pulses("t4_after_done", base + 3, 50);
    check_eq("t4_err_sticky", 32'(timeout_err), 32'd1);

    // Reset in the middle of WAIT
    do_reset();
    mem_lat = 20; mem_rdata = 32'h55;
    push_exp(0, 2'b01, 32'h0, 32'h55, 20, 0);
    issue(0, 2'b01, 32'h0, 1);
    wait_busy("t5_grant", 20);
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    reset = 1'b1;
    for (int i = 0; i < N_PROC; i++) req_cnt[i] = 0;
    #1;
    check_eq("t5_mem_op", 32'(mem_op), 32'd0);
    check_eq("t5_p_signal", 32'(p_signal), 32'd0);
    check_eq("t5_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      check_eq("t5_no_pulse", 32'(p_signal), 32'd0);
    end

    // Op 11 is not a request
    issue(0, 2'b11, 32'h1234, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      check_eq("t6_busy", 32'(busy), 32'd0);
      check_eq("t6_mem_op", 32'(mem_op), 32'd0);
    end
    req_cnt[0] = 0;
    repeat (2) @(negedge clk); #1;

    check_eq("end_queue_empty", 32'(exp_q.size()), 32'd0);
    check_eq("end_no_open_txn", 32'(in_txn), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/accumulator_bus_arbiter.md
Name: accumulator_bus_arbiter

Overview:
Shares the single op/signal handshake port of the accumulator memory among N_PROC processor cores. Each core issues FETCH or SEND requests. The arbiter grants one request at a time in round-robin order and forwards the granted op and write data to the memory. When the memory signals completion, the arbiter returns the read data and a one-cycle signal pulse to the granted core. A watchdog aborts transactions the memory never completes.

Parameters:
N_PROC, 4, number of requesting processors (2..8)
ID_W, 2, grant index width; 2**ID_W >= N_PROC
DATA_W, 32, operand width
TIMEOUT, 2047, maximum cycles in WAIT before abort (fits 16-bit counter)

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  asynchronous, active-high reset
p_op  input  2*N_PROC  per-core op, core i at [2i+1:2i]; 00 NOP, 01 FETCH, 10 SEND, 11 treated as NOP
p_write  input  DATA_W*N_PROC  per-core write data, core i at [DATA_W*i +: DATA_W]
p_signal  output  N_PROC  one-hot completion pulse to the granted core
p_read  output  DATA_W  read data shared by all cores; valid only while the matching p_signal bit is high
mem_op  output  2  op to the memory (registered)
mem_write  output  DATA_W  write data to the memory (registered)
mem_read  input  DATA_W  memory read bus
mem_signal  input  1  memory completion pulse
busy  output  1  high in any state other than IDLE
grant_id  output  ID_W  index of the current or last granted core
timeout_err  output  1  sticky; set on a watchdog abort; cleared only by reset

Behaviour:
- Reset values: state IDLE, mem_op 00, mem_write 0, p_signal 0, p_read 0, grant_id 0, rr pointer = N_PROC-1, wd counter 0, timeout_err 0. Reset mid-transaction abandons the transaction; no p_signal is generated for it.
- States: IDLE, WAIT, RELEASE.
- IDLE:
  - A core is requesting when its p_op is 01 or 10.
  - Search cores rr+1, rr+2, ... mod N_PROC. The first requester found wins.
  - On the next edge: grant_id <= winner, rr <= winner, mem_op <= its op, mem_write <= its data, wd <= 0, go to WAIT.
  - No requester: remain in IDLE with mem_op 00.
- WAIT:
  - mem_op and mem_write are held constant. Changes to the granted core's p_op are ignored.
  - wd increments every cycle.
  - On the first cycle mem_signal is high: mem_op <= 00, p_read <= mem_read, p_signal[grant_id] <= 1, go to RELEASE.
    - mem_op therefore drops one edge after the memory's pulse, before the memory can re-sample op.
  - If wd reaches TIMEOUT with no mem_signal: mem_op <= 00, p_read <= 0, p_signal[grant_id] <= 1, timeout_err <= 1, go to RELEASE.
  - If mem_signal and timeout occur in the same cycle, mem_signal wins and timeout_err is not set.
- RELEASE:
  - Lasts exactly one cycle. p_signal is high for this single cycle, then clears. mem_op stays 00. Go to IDLE.
  - This guarantees at least one full NOP cycle on mem_op between transactions.
- Core contract: the granted core drives p_op to 00 at the edge where it samples its p_signal high, so the core is NOP by the time the arbiter is back in IDLE.
- Latency: minimum request-to-p_signal is 3 edges, i.e. the grant edge, the memory's own latency, and the capture edge.
- Fairness: with all cores continuously requesting, grants rotate 0,1,2,3,0,... and no core waits more than N_PROC transactions.
- mem_signal while in IDLE or RELEASE is ignored.

Test Plan:
1. Reset, then core 2 issues a FETCH; memory responds with mem_read=0x0000_00A5 after 4 cycles -> mem_op=01 while granted, p_signal=0100 for 1 cycle, p_read=0xA5, then mem_op=00 for at least 1 cycle.
2. All 4 cores issue SEND with data 0x11,0x22,0x33,0x44 -> mem_write sequence 0x11,0x22,0x33,0x44; grant_id sequence 0,1,2,3; busy low only between grants.
3. Core 1 requests continuously, and core 3 starts requesting during core 1's WAIT -> the next grant goes to core 3, then core 1.
4. Memory never asserts mem_signal -> after 2047 WAIT cycles: p_signal pulse with p_read=0, timeout_err=1 and sticky; the next request is still served normally.
5. Assert reset during WAIT -> mem_op=00, p_signal=0, busy=0 immediately, with no pulse for the aborted request.
6. Core 0 drives op=11 -> ignored; stays IDLE with mem_op=00.
